wishbone_bus_if: RTL

Bridge between one OpenMIPS core memory port (instruction or data) and a Wishbone B4 classic master bus. The core issues single-cycle-style requests (`ce`/`we`/`sel`/`addr`/`data`). The block converts each request into a registered Wishbone cycle and holds the pipeline with `stallreq_o` until `ack`. Two instances sit directly outside the core: one on the `rom_*` port and one on the `ram_*` port. Both `stallreq_o` outputs feed the pipeline controller's stall request inputs.

---
 rtl/wishbone_bus_if.sv | 100 ++++++++++
 1 files changed

// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if: bridges an OpenMIPS core memory port onto a Wishbone B4 classic master bus
module wishbone_bus_if (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_data_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, WAIT_FOR_STALL = 2'b10} state_t;
    state_t state, state_nxt;
    logic [31:0] rd_buf;
    logic start;
    assign start = cpu_ce_i && !flush_i;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    // next state plus the stall request and read data seen by the core
    always_comb begin
        state_nxt = IDLE;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        case (state)
            IDLE: begin
                state_nxt = start ? BUSY : IDLE;
                stallreq_o = start;
            end
            BUSY: begin
                state_nxt = wishbone_ack_i ? ((|stall_i) ? WAIT_FOR_STALL : IDLE) : (flush_i ? IDLE : BUSY);
                stallreq_o = !wishbone_ack_i;
                cpu_data_o = (wishbone_ack_i && !cpu_we_i) ? wishbone_data_i : 32'h0;
            end
            WAIT_FOR_STALL: begin
                state_nxt = (|stall_i) ? WAIT_FOR_STALL : IDLE;
                cpu_data_o = rd_buf;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // registered bus outputs and the read buffer held across foreign stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            wishbone_addr_o <= 32'h0;
            wishbone_data_o <= 32'h0;
            wishbone_we_o <= 1'b0;
            wishbone_sel_o <= 4'h0;
            wishbone_stb_o <= 1'b0;
            wishbone_cyc_o <= 1'b0;
            rd_buf <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    wishbone_addr_o <= start ? cpu_addr_i : 32'h0;
                    wishbone_data_o <= start ? cpu_data_i : 32'h0;
                    wishbone_we_o <= start && cpu_we_i;
                    wishbone_sel_o <= start ? cpu_sel_i : 4'h0;
                    wishbone_stb_o <= start;
                    wishbone_cyc_o <= start;
                    if (start) rd_buf <= 32'h0;
                end
                BUSY: begin
                    if (wishbone_ack_i || flush_i) begin
                        wishbone_addr_o <= 32'h0;
                        wishbone_data_o <= 32'h0;
                        wishbone_we_o <= 1'b0;
                        wishbone_sel_o <= 4'h0;
                        wishbone_stb_o <= 1'b0;
                        wishbone_cyc_o <= 1'b0;
                    end
                    if (wishbone_ack_i && !cpu_we_i) rd_buf <= wishbone_data_i;
                    else if (!wishbone_ack_i && flush_i) rd_buf <= 32'h0;
                end
                WAIT_FOR_STALL: rd_buf <= rd_buf;
                default: begin
                    wishbone_addr_o <= 32'h0;
                    wishbone_data_o <= 32'h0;
                    wishbone_we_o <= 1'b0;
                    wishbone_sel_o <= 4'h0;
                    wishbone_stb_o <= 1'b0;
                    wishbone_cyc_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
